// File: rtl/s64x7_bus_arbiter_pkg.sv
// rtl/s64x7_bus_arbiter_pkg.sv - shared encodings and widths for the S64X7 bus arbiter
//
// Holds the arbiter state encoding (which doubles as the one-hot gnt_o value)
// and the bus field widths used by the interface and the arbiter.
// Ports: none (package).

package s64x7_bus_arbiter_pkg;

  localparam int ADR_W = 61;  // doubleword address [63:3]
  localparam int SEL_W = 8;   // byte lane selects
  localparam int DAT_W = 64;

  // OWN0/OWN1 are one-hot so the state register can drive gnt_o directly.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/s64x7_bus_arbiter_if.sv
// rtl/s64x7_bus_arbiter_if.sv - bus bundle between CPU, DMA, arbiter and memory slave
//
// Signals:
//   m0_*  CPU side: cyc/stb/we/vpa/adr/sel/dat_i requests, dat_o/ack_o/err_o returns
//   m1_*  DMA side: same without vpa
//   s_*   slave side: cyc/stb/we/vpa/adr/sel/dat_o outputs, dat_i/ack_i returns
//   gnt_o one-hot current owner
// Modports:
//   master  the arbiter's view (it masters the shared slave bus)
//   slave   the environment's view (CPU, DMA and memory models)

interface s64x7_bus_arbiter_if;
  import s64x7_bus_arbiter_pkg::*;

  logic             m0_cyc_i, m0_stb_i, m0_we_i, m0_vpa_i;
  logic [ADR_W-1:0] m0_adr_i;
  logic [SEL_W-1:0] m0_sel_i;
  logic [DAT_W-1:0] m0_dat_i;
  logic [DAT_W-1:0] m0_dat_o;
  logic             m0_ack_o, m0_err_o;

  logic             m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADR_W-1:0] m1_adr_i;
  logic [SEL_W-1:0] m1_sel_i;
  logic [DAT_W-1:0] m1_dat_i;
  logic [DAT_W-1:0] m1_dat_o;
  logic             m1_ack_o, m1_err_o;

  logic [ADR_W-1:0] s_adr_o;
  logic [SEL_W-1:0] s_sel_o;
  logic [DAT_W-1:0] s_dat_o;
  logic             s_cyc_o, s_stb_o, s_we_o, s_vpa_o;
  logic [DAT_W-1:0] s_dat_i;
  logic             s_ack_i;

  logic [1:0]       gnt_o;

  modport master (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_vpa_i, m0_adr_i, m0_sel_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_sel_o, s_dat_o, s_cyc_o, s_stb_o, s_we_o, s_vpa_o,
    input  s_dat_i, s_ack_i,
    output gnt_o
  );

  modport slave (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_vpa_i, m0_adr_i, m0_sel_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_sel_o, s_dat_o, s_cyc_o, s_stb_o, s_we_o, s_vpa_o,
    output s_dat_i, s_ack_i,
    input  gnt_o
  );

endinterface

// File: rtl/s64x7_rr_pick.sv
// rtl/s64x7_rr_pick.sv - combinational two-way round-robin picker
//
// Ports:
//   req[1:0]  request from m1 (bit 1) and m0 (bit 0)
//   last      most recent owner (0 = m0, 1 = m1)
//   gnt[1:0]  one-hot pick, 00 when nothing is requested

module s64x7_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie the master that did not own the bus most recently wins.
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/s64x7_bus_arbiter.sv
// rtl/s64x7_bus_arbiter.sv - two-master / one-slave S64X7 memory bus arbiter
//
// Shares the slave bus between the CPU (m0) and the DMA/video engine (m1).
// The grant is taken per transaction and held while the owner keeps cyc high.
// Optional unacknowledged-transfer abort: define S64X7_ARB_TIMEOUT_EN.
// Parameters:
//   TIMEOUT  cycles a granted stb may wait for ack before abort (2..65535)
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  asynchronous active-high reset
//   bus      s64x7_bus_arbiter_if.master (masters, slave and gnt_o)

module s64x7_bus_arbiter
  import s64x7_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  s64x7_bus_arbiter_if.master   bus
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
    $error("s64x7_bus_arbiter: TIMEOUT must be within 2..65535");
  end

  arb_state_t state;
  logic       last;          // 1 = m1 owned most recently
  logic       own_cyc;
  logic       own_stb;
  logic       timeout_hit;
  logic       bus_free;
  logic [1:0] pick;

  s64x7_rr_pick u_pick (
    .req  ({bus.m1_cyc_i, bus.m0_cyc_i}),
    .last (last),
    .gnt  (pick)
  );

  // A timed-out owner is treated exactly like one that dropped cyc.
  assign bus_free = (state == ARB_IDLE) || !own_cyc || timeout_hit;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
    end else if (bus_free) begin
      case (pick)
        2'b01: begin
          state <= ARB_OWN0;
          last  <= 1'b0;
        end
        2'b10: begin
          state <= ARB_OWN1;
          last  <= 1'b1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef S64X7_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign timeout_hit = (state != ARB_IDLE) && (wait_cnt == 16'(TIMEOUT));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt <= 16'd0;
    end else if (bus_free) begin
      wait_cnt <= 16'd0;
    end else if (own_stb && !bus.s_ack_i) begin
      wait_cnt <= wait_cnt + 16'd1;
    end else begin
      wait_cnt <= 16'd0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Owner mux toward the slave and ack/err steering back to the owner.
  always_comb begin
    own_cyc      = 1'b0;
    own_stb      = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_vpa_o  = 1'b0;
    bus.s_adr_o  = '0;
    bus.s_sel_o  = '0;
    bus.s_dat_o  = '0;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    case (state)
      ARB_OWN0: begin
        own_cyc      = bus.m0_cyc_i;
        own_stb      = bus.m0_stb_i;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_vpa_o  = bus.m0_vpa_i;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.m0_ack_o = bus.s_ack_i && !timeout_hit;
        bus.m0_err_o = timeout_hit;
      end
      ARB_OWN1: begin
        own_cyc      = bus.m1_cyc_i;
        own_stb      = bus.m1_stb_i;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.m1_ack_o = bus.s_ack_i && !timeout_hit;
        bus.m1_err_o = timeout_hit;
      end
      default: ;
    endcase
    // The aborted cycle is withdrawn from the slave in the same cycle.
    bus.s_cyc_o = own_cyc && !timeout_hit;
    bus.s_stb_o = own_stb && !timeout_hit;
  end

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.gnt_o    = state;

endmodule
